// File: rtl/mem_model_burst.sv
// mem_model_burst: simulation DRAM stand-in; independent read and write
// burst channels on a word-addressed array.
//   read_request_*  : read burst request (addr, len = beats-1, size)
//   read_data_*     : read beats out of a backpressure buffer, last flag
//   write_request_* : write burst request (addr, len = beats-1, size)
//   write_data_*    : write beats with byte strobes
//   write_resp_*    : one response per completed write burst
// Optional: define MEM_MODEL_STALL_EN for LFSR-driven issue/accept stalls.
module mem_model_burst #(
    parameter int AXI_AWIDTH    = 32,
    parameter int AXI_DWIDTH    = 32,
    parameter int MEM_AWIDTH    = 14,
    parameter int READ_LATENCY  = 2,
    parameter int RD_FIFO_DEPTH = READ_LATENCY + 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    read_request_valid,
    output logic                    read_request_ready,
    input  logic [AXI_AWIDTH-1:0]   read_request_addr,
    input  logic [31:0]             read_len,
    input  logic [2:0]              read_size,
    output logic [AXI_DWIDTH-1:0]   read_data,
    output logic                    read_data_valid,
    output logic                    read_data_last,
    input  logic                    read_data_ready,
    input  logic                    write_request_valid,
    output logic                    write_request_ready,
    input  logic [AXI_AWIDTH-1:0]   write_request_addr,
    input  logic [31:0]             write_len,
    input  logic [2:0]              write_size,
    input  logic [AXI_DWIDTH-1:0]   write_data,
    input  logic [AXI_DWIDTH/8-1:0] write_strb,
    input  logic                    write_data_valid,
    output logic                    write_data_ready,
    output logic                    write_resp_valid,
    input  logic                    write_resp_ready
);

    localparam int NB     = AXI_DWIDTH / 8;
    localparam int BSHIFT = $clog2(NB);
    localparam int L      = READ_LATENCY;
    localparam int PW     = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
    localparam int CW     = $clog2(RD_FIFO_DEPTH + 1);
    localparam int CW1    = CW + 1;

    localparam logic [2:0]    MAX_SIZE = 3'(BSHIFT);
    localparam logic [PW-1:0] PTR_LAST = PW'(RD_FIFO_DEPTH - 1);

    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DRAIN} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

    // Oversized beats are treated as full-width beats.
    function automatic logic [2:0] clamp_size(input logic [2:0] s);
        return (s > MAX_SIZE) ? MAX_SIZE : s;
    endfunction

    // Array index wraps at 2^MEM_AWIDTH words.
    function automatic logic [MEM_AWIDTH-1:0] widx(input logic [31:0] a);
        return MEM_AWIDTH'(a >> BSHIFT);
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    logic [AXI_DWIDTH-1:0] mem [2**MEM_AWIDTH];

    logic stall;

`ifdef MEM_MODEL_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign stall = lfsr[0];
`else
    assign stall = 1'b0;
`endif

    // ---------------- read side ----------------
    rd_state_t             rd_state;
    logic [31:0]           rd_addr;
    logic [31:0]           rd_len;
    logic [2:0]            rd_size;
    logic [31:0]           rd_beat;
    logic [L-1:0]          pipe_v;
    logic [L-1:0]          pipe_l;
    logic [AXI_DWIDTH-1:0] pipe_d [L];
    logic [CW-1:0]         in_flight;
    logic [AXI_DWIDTH-1:0] fifo_d [RD_FIFO_DEPTH];
    logic                  fifo_l [RD_FIFO_DEPTH];
    logic [PW-1:0]         fifo_wp;
    logic [PW-1:0]         fifo_rp;
    logic [CW-1:0]         fifo_count;
    logic                  rd_credit;
    logic                  rd_issue;
    logic                  rd_retire;
    logic                  rd_pop;

    // A beat is only issued when a buffer slot is reserved for it, so the
    // buffer cannot overflow whatever the consumer does.
    assign rd_credit = ({1'b0, in_flight} + {1'b0, fifo_count})
                       < CW1'(RD_FIFO_DEPTH);
    assign rd_issue  = (rd_state == R_ISSUE) && rd_credit && !stall;
    assign rd_retire = pipe_v[L-1];
    assign rd_pop    = read_data_valid && read_data_ready;

    assign read_request_ready = (rd_state == R_IDLE);
    assign read_data_valid    = (fifo_count != '0);
    assign read_data          = fifo_d[fifo_rp];
    assign read_data_last     = read_data_valid && fifo_l[fifo_rp];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_state   <= R_IDLE;
            rd_addr    <= '0;
            rd_len     <= '0;
            rd_size    <= '0;
            rd_beat    <= '0;
            pipe_v     <= '0;
            pipe_l     <= '0;
            in_flight  <= '0;
            fifo_wp    <= '0;
            fifo_rp    <= '0;
            fifo_count <= '0;
        end else begin
            pipe_v[0] <= rd_issue;
            pipe_l[0] <= rd_issue && (rd_beat == rd_len);
            for (int i = 1; i < L; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_l[i] <= pipe_l[i-1];
            end

            unique case ({rd_issue, rd_retire})
                2'b10:   in_flight <= in_flight + 1'b1;
                2'b01:   in_flight <= in_flight - 1'b1;
                default: in_flight <= in_flight;
            endcase

            if (rd_retire) fifo_wp <= ptr_inc(fifo_wp);
            if (rd_pop)    fifo_rp <= ptr_inc(fifo_rp);

            unique case ({rd_retire, rd_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase

            unique case (rd_state)
                R_IDLE: begin
                    if (read_request_valid) begin
                        rd_addr  <= 32'(read_request_addr);
                        rd_len   <= read_len;
                        rd_size  <= clamp_size(read_size);
                        rd_beat  <= '0;
                        rd_state <= R_ISSUE;
                    end
                end
                R_ISSUE: begin
                    if (rd_issue) begin
                        rd_addr <= rd_addr + (32'd1 << rd_size);
                        if (rd_beat == rd_len) begin
                            rd_state <= R_DRAIN;
                        end else begin
                            rd_beat <= rd_beat + 32'd1;
                        end
                    end
                end
                R_DRAIN: begin
                    if (in_flight == '0 && fifo_count == '0) begin
                        rd_state <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // Array read uses the pre-edge contents, so a same-cycle write to the
    // same word is not visible to this beat.
    always_ff @(posedge clk) begin
        pipe_d[0] <= mem[widx(rd_addr)];
        for (int i = 1; i < L; i++) begin
            pipe_d[i] <= pipe_d[i-1];
        end
        if (rd_retire) begin
            fifo_d[fifo_wp] <= pipe_d[L-1];
            fifo_l[fifo_wp] <= pipe_l[L-1];
        end
    end

    // ---------------- write side ----------------
    wr_state_t   wr_state;
    logic [31:0] wr_addr;
    logic [31:0] wr_len;
    logic [2:0]  wr_size;
    logic [31:0] wr_beat;
    logic        wr_fire;

    assign write_request_ready = (wr_state == W_IDLE);
    assign write_data_ready    = (wr_state == W_DATA) && !stall;
    assign write_resp_valid    = (wr_state == W_RESP);
    assign wr_fire             = write_data_valid && write_data_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_state <= W_IDLE;
            wr_addr  <= '0;
            wr_len   <= '0;
            wr_size  <= '0;
            wr_beat  <= '0;
        end else begin
            unique case (wr_state)
                W_IDLE: begin
                    if (write_request_valid) begin
                        wr_addr  <= 32'(write_request_addr);
                        wr_len   <= write_len;
                        wr_size  <= clamp_size(write_size);
                        wr_beat  <= '0;
                        wr_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wr_fire) begin
                        wr_addr <= wr_addr + (32'd1 << wr_size);
                        if (wr_beat == wr_len) begin
                            wr_state <= W_RESP;
                        end else begin
                            wr_beat <= wr_beat + 32'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (write_resp_ready) wr_state <= W_IDLE;
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // A beat arriving on a reset edge is dropped along with its burst.
    always_ff @(posedge clk) begin
        if (wr_fire && rst_n) begin
            for (int b = 0; b < NB; b++) begin
                if (write_strb[b]) begin
                    mem[widx(wr_addr)][8*b +: 8] <= write_data[8*b +: 8];
                end
            end
        end
    end

endmodule
